// File: rtl/rx_frame_buffer.sv
// rtl/rx_frame_buffer.sv - framed UART upload buffer: length/checksum check, paced payload release
// Build option: define RX_FRAME_CRC8_EN to check CRC-8 (poly 0x07) instead of the XOR checksum.
module rx_frame_buffer #(
   parameter int         MAX_PAYLOAD    = 128,
   parameter int         TIMEOUT_CYCLES = 5_000_000,
   parameter int         OUT_GAP        = 4,
   parameter logic [7:0] SOF_BYTE       = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_in,
   input  logic [7:0] byte_in,
   output logic       valid_out,
   output logic [7:0] byte_out,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int PW = $clog2(MAX_PAYLOAD + 1);
   localparam int AW = $clog2(MAX_PAYLOAD);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = (OUT_GAP > 1) ? $clog2(OUT_GAP) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GET_LEN = 3'd1;
   localparam logic [2:0] S_GET_PAY = 3'd2;
   localparam logic [2:0] S_GET_CHK = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;

   localparam logic [1:0] E_NONE = 2'd0;
   localparam logic [1:0] E_LEN  = 2'd1;
   localparam logic [1:0] E_CHK  = 2'd2;
   localparam logic [1:0] E_TMO  = 2'd3;

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] len_q, len_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]    acc_q, acc_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          valid_out_q, valid_out_d;
   logic [7:0]    byte_out_q, byte_out_d;
   logic          frame_ok_q, frame_ok_d;
   logic          frame_err_q, frame_err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          wr_en;
   logic          in_frame;
   logic          expire;

   logic [7:0]    mem [MAX_PAYLOAD];

   // Fold one byte into the running frame check value.
   function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
`ifdef RX_FRAME_CRC8_EN
      logic [7:0] c;
      c = acc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
`else
      return acc ^ data;
`endif
   endfunction

   // Next-state logic: frame parsing, idle timeout and paced drain.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      acc_d       = acc_q;
      tmo_d       = tmo_q;
      gap_d       = gap_q;
      valid_out_d = 1'b0;
      byte_out_d  = byte_out_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      wr_en       = 1'b0;

      in_frame = (state_q == S_GET_LEN) || (state_q == S_GET_PAY) || (state_q == S_GET_CHK);
      // A byte landing on the expiry cycle keeps the frame alive.
      expire   = in_frame && !valid_in && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

      if (in_frame) begin
         tmo_d = valid_in ? '0 : tmo_q + TW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (valid_in && byte_in == SOF_BYTE) begin
               state_d  = S_GET_LEN;
               tmo_d    = '0;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
            end
         end
         S_GET_LEN: begin
            if (valid_in) begin
               if (byte_in == 8'd0 || 32'(byte_in) > 32'(MAX_PAYLOAD)) begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = E_LEN;
                  tmo_d       = '0;
               end else begin
                  len_d   = PW'(byte_in);
                  acc_d   = chk_fold(8'h00, byte_in);
                  state_d = S_GET_PAY;
               end
            end else if (expire) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
               err_code_d  = E_TMO;
               tmo_d       = '0;
            end
         end
         S_GET_PAY: begin
            if (valid_in) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + PW'(1);
               acc_d    = chk_fold(acc_q, byte_in);
               if (wr_ptr_q + PW'(1) == len_q) begin
                  state_d = S_GET_CHK;
               end
            end else if (expire) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
               err_code_d  = E_TMO;
               tmo_d       = '0;
            end
         end
         S_GET_CHK: begin
            if (valid_in) begin
               tmo_d = '0;
               if (byte_in == acc_q) begin
                  state_d    = S_DRAIN;
                  frame_ok_d = 1'b1;
                  err_code_d = E_NONE;
                  rd_ptr_d   = '0;
                  gap_d      = '0;
               end else begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = E_CHK;
               end
            end else if (expire) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
               err_code_d  = E_TMO;
               tmo_d       = '0;
            end
         end
         S_DRAIN: begin
            // Stay one cycle past the last emission so busy covers the final valid_out.
            if (rd_ptr_q == len_q) begin
               state_d = S_IDLE;
            end else if (gap_q == '0) begin
               valid_out_d = 1'b1;
               byte_out_d  = mem[rd_ptr_q[AW-1:0]];
               rd_ptr_d    = rd_ptr_q + PW'(1);
               gap_d       = GW'(OUT_GAP - 1);
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Payload storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q[AW-1:0]] <= byte_in;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         acc_q       <= '0;
         tmo_q       <= '0;
         gap_q       <= '0;
         valid_out_q <= 1'b0;
         byte_out_q  <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= E_NONE;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         acc_q       <= acc_d;
         tmo_q       <= tmo_d;
         gap_q       <= gap_d;
         valid_out_q <= valid_out_d;
         byte_out_q  <= byte_out_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign valid_out = valid_out_q;
   assign byte_out  = byte_out_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb/tb_rx_frame_buffer.sv - directed scoreboard bench for rx_frame_buffer
module tb_rx_frame_buffer;

   localparam int         MAXP = 128;
   localparam int         TMO  = 1000;
   localparam int         GAP  = 4;
   localparam logic [7:0] SOF  = 8'hA5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_in = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       valid_out;
   logic [7:0] byte_out;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   rx_frame_buffer #(
      .MAX_PAYLOAD   (MAXP),
      .TIMEOUT_CYCLES(TMO),
      .OUT_GAP       (GAP),
      .SOF_BYTE      (SOF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .byte_in  (byte_in),
      .valid_out(valid_out),
      .byte_out (byte_out),
      .frame_ok (frame_ok),
      .frame_err(frame_err),
      .err_code (err_code),
      .busy     (busy)
   );

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         last_cyc = 0;
   int         vo_n = 0;
   int         ok_n = 0;
   int         err_n = 0;
   int         ok_cyc = -1;
   int         err_cyc = -1;
   int         vo_cyc[$];
   logic [7:0] exp_q[$];
   logic [7:0] pay[$];

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fold(input logic [7:0] a, input logic [7:0] b);
`ifdef RX_FRAME_CRC8_EN
      logic [7:0] c;
      c = a ^ b;
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
`else
      return a ^ b;
`endif
   endfunction

   // Output monitor: scoreboard pop on every valid_out, pulse bookkeeping.
   initial forever begin
      @(negedge clk);
      if (valid_out) begin
         vo_n++;
         vo_cyc.push_back(cyc);
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_valid_out observed=%0h expected=none", byte_out);
         end
         if (exp_q.size() != 0) check("byte_out", byte_out, exp_q.pop_front());
      end
      if (frame_ok || frame_err) check("ok_err_exclusive", frame_ok & frame_err, 0);
      if (frame_ok) begin ok_n++; ok_cyc = cyc; end
      if (frame_err) begin err_n++; err_cyc = cyc; end
   end

   // Called at a negedge; drives one byte for exactly one cycle.
   task automatic send(input logic [7:0] b);
      valid_in = 1'b1;
      byte_in  = b;
      last_cyc = cyc;
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) @(negedge clk);
      check("idle_reached", busy, 0);
   endtask

   // Sends SOF, LEN, pay[], CHK; optional stall after the first payload byte.
   task automatic send_frame(input bit corrupt, input int stall);
      logic [7:0] chk;
      int         first;
      chk = fold(8'h00, 8'(pay.size()));
      foreach (pay[i]) chk = fold(chk, pay[i]);
      if (!corrupt) foreach (pay[i]) exp_q.push_back(pay[i]);
      send(SOF);
      send(8'(pay.size()));
      first = 0;
      foreach (pay[i]) begin
         send(pay[i]);
         if (i == 0) first = last_cyc;
         if (i == 0 && stall > 0) wait_to(first + stall);
      end
      send(corrupt ? (chk ^ 8'h5A) : chk);
   endtask

   int t, b_ok, b_err, vn;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid_out", valid_out, 0);
      check("rst_byte_out", byte_out, 0);
      check("rst_frame_ok", frame_ok, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // Good frame: timing of frame_ok, valid_out spacing and busy drop.
      pay = '{8'h11, 8'h22, 8'h33};
      vo_cyc.delete();
      b_ok = ok_n;
      send_frame(0, 0);
      t = last_cyc;
      wait_to(t + 10);
      check("last_vo_high", valid_out, 1);
      check("busy_during_last_vo", busy, 1);
      @(negedge clk);
      check("busy_after_last_vo", busy, 0);
      check("good_ok_count", ok_n - b_ok, 1);
      check("good_ok_cycle", ok_cyc - t, 1);
      check("good_vo_count", vo_cyc.size(), 3);
      if (vo_cyc.size() == 3) begin
         check("vo0_cycle", vo_cyc[0] - t, 2);
         check("vo1_cycle", vo_cyc[1] - t, 2 + GAP);
         check("vo2_cycle", vo_cyc[2] - t, 2 + 2 * GAP);
      end
      check("good_err_code", err_code, 0);

      // Bad checksum, then a one-byte good frame.
      pay = '{8'h0B, 8'h0C};
      b_err = err_n;
      vn = vo_n;
      send_frame(1, 0);
      t = last_cyc;
      repeat (10) @(negedge clk);
      check("badchk_err_count", err_n - b_err, 1);
      check("badchk_err_cycle", err_cyc - t, 1);
      check("badchk_err_code", err_code, 2);
      check("badchk_no_output", vo_n - vn, 0);
      pay = '{8'h7E};
      b_ok = ok_n;
      send_frame(0, 0);
      wait_idle(50);
      check("single_ok", ok_n - b_ok, 1);
      check("single_err_code", err_code, 0);

      // Bad lengths: zero and one above MAX_PAYLOAD.
      b_err = err_n;
      send(SOF); send(8'h00);
      t = last_cyc;
      @(negedge clk);
      check("len0_err_code", err_code, 1);
      check("len0_err_cycle", err_cyc - t, 1);
      send(SOF); send(8'h81); send(8'h11);
      repeat (2) @(negedge clk);
      check("len81_err_code", err_code, 1);
      check("badlen_err_count", err_n - b_err, 2);
      check("badlen_idle", busy, 0);

      // Maximum-size frame.
      pay.delete();
      for (int i = 0; i < MAXP; i++) pay.push_back(8'($urandom_range(0, 255)));
      vn = vo_n;
      send_frame(0, 0);
      wait_idle(MAXP * GAP + 20);
      check("max_vo_count", vo_n - vn, MAXP);

      // Timeout after silence.
      b_err = err_n;
      send(SOF); send(8'h03); send(8'h11);
      t = last_cyc;
      wait_to(t + TMO);
      check("tmo_not_early", frame_err, 0);
      @(negedge clk);
      check("tmo_err_pulse", frame_err, 1);
      check("tmo_err_code", err_code, 3);
      check("tmo_idle", busy, 0);
      @(negedge clk);
      check("tmo_err_count", err_n - b_err, 1);

      // Byte arriving exactly on the expiry cycle keeps the frame.
      pay = '{8'h11, 8'h22, 8'h33};
      b_err = err_n;
      b_ok = ok_n;
      send_frame(0, TMO);
      wait_idle(50);
      check("coincide_no_err", err_n - b_err, 0);
      check("coincide_ok", ok_n - b_ok, 1);

      // Leading noise; SOF value inside payload is data.
      send(8'h00); send(8'hFF);
      pay = '{8'hA5};
      b_ok = ok_n;
      send_frame(0, 0);
      wait_idle(50);
      check("noise_ok", ok_n - b_ok, 1);

      // Bytes injected during drain are discarded.
      pay = '{8'hC1, 8'hC2, 8'hC3};
      b_ok = ok_n;
      b_err = err_n;
      send_frame(0, 0);
      send(SOF); send(8'h01); send(SOF); send(8'h55); send(8'h66);
      wait_idle(50);
      check("drain_inject_ok", ok_n - b_ok, 1);
      check("drain_inject_err", err_n - b_err, 0);

      // Reset in the middle of a drain.
      pay = '{8'hD1, 8'hD2, 8'hD3};
      vn = vo_n;
      send_frame(0, 0);
      for (int i = 0; i < 20 && vo_n == vn; i++) @(negedge clk);
      check("mid_drain_first_vo", vo_n - vn, 1);
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("mrst_valid_out", valid_out, 0);
      check("mrst_byte_out", byte_out, 0);
      check("mrst_frame_ok", frame_ok, 0);
      check("mrst_frame_err", frame_err, 0);
      check("mrst_err_code", err_code, 0);
      check("mrst_busy", busy, 0);
      rst = 1'b0;
      vn = vo_n;
      b_err = err_n;
      repeat (20) @(negedge clk);
      check("mrst_no_more_vo", vo_n - vn, 0);
      check("mrst_no_err", err_n - b_err, 0);
      pay = '{8'hE1, 8'hE2};
      b_ok = ok_n;
      vn = vo_n;
      send_frame(0, 0);
      wait_idle(50);
      check("post_rst_ok", ok_n - b_ok, 1);
      check("post_rst_vo", vo_n - vn, 2);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
